// File: rtl/sblk_inst_sched.sv
// Instruction scheduler for a superblock row: a host-fed FIFO plus an issue/complete FSM with column drain skew.
// Define SBLK_SCHED_TIMEOUT_EN to compile in the WAIT_START timeout counter that drives err_timeout.
module sblk_inst_sched #(
  parameter int WID_INST   = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int N_COLUMN   = 4,
  parameter int START_TO   = 64
) (
  input  logic                clk_l,
  input  logic                rst,
  input  logic [WID_INST-1:0] inst_in_data,
  input  logic                inst_in_vld,
  output logic                inst_in_rdy,
  input  logic                flush,
  output logic [WID_INST-1:0] inst_data,
  output logic                inst_en,
  input  logic                status_sblk,
  output logic                sched_idle,
  output logic                done_pulse,
  output logic [15:0]         done_cnt,
  output logic                err_timeout
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int DRAIN_LEN = (N_COLUMN > 1) ? N_COLUMN - 1 : 1;
  localparam int DRAIN_W   = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN      = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WID_INST-1:0] inst_data_q, inst_data_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [15:0]         done_cnt_q, done_cnt_d;
  logic                rdy_q, rdy_d;
  logic [WID_INST-1:0] mem_q [FIFO_DEPTH];

  logic empty, full, push, pop, drain_last, to_expire;

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign inst_in_rdy = rdy_q && !full;
  assign push        = inst_in_vld && inst_in_rdy && !flush;
  assign pop         = (state_q == ST_ISSUE) && !empty;
  assign drain_last  = (state_q == ST_DRAIN) && (drain_q == DRAIN_LAST);

  assign inst_en     = (state_q == ST_ISSUE);
  assign inst_data   = inst_data_q;
  assign sched_idle  = (state_q == ST_IDLE) && empty;
  assign done_pulse  = drain_last;
  assign done_cnt    = done_cnt_q;

  // NOTE: the queue storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk_l) begin
    if (push) mem_q[wr_ptr_q] <= inst_in_data;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdy_d    = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // The issued word is latched on entry to ISSUE so it stays stable after the pop.
  always_comb begin
    state_d     = state_q;
    inst_data_d = inst_data_q;
    drain_d     = drain_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !status_sblk) begin
          state_d     = ST_ISSUE;
          inst_data_d = mem_q[rd_ptr_q];
        end
      end
      ST_ISSUE: state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (status_sblk)    state_d = ST_WAIT_DONE;
        else if (to_expire) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (!status_sblk) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_last) begin
          state_d    = ST_IDLE;
          done_cnt_d = done_cnt_q + 16'd1;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inst_data_q <= '0;
      drain_q     <= '0;
      done_cnt_q  <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inst_data_q <= inst_data_d;
      drain_q     <= drain_d;
      done_cnt_q  <= done_cnt_d;
      rdy_q       <= rdy_d;
    end
  end

`ifdef SBLK_SCHED_TIMEOUT_EN
  localparam int TO_W = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  assign to_expire   = (state_q == ST_WAIT_START) && !status_sblk && (to_cnt_q == TO_LAST);
  assign err_timeout = err_q;

  always_comb begin
    to_cnt_d = to_cnt_q;
    err_d    = err_q | to_expire;
    if (state_q == ST_ISSUE)           to_cnt_d = '0;
    else if (state_q == ST_WAIT_START) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
`else
  assign to_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sblk_inst_sched.sv
// Directed bench for sblk_inst_sched with default parameters (N_COLUMN=4, FIFO_DEPTH=4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sblk_inst_sched;

  logic        clk_l = 1'b0;
  logic        rst;
  logic [14:0] inst_in_data;
  logic        inst_in_vld;
  logic        inst_in_rdy;
  logic        flush;
  logic [14:0] inst_data;
  logic        inst_en;
  logic        status_sblk;
  logic        sched_idle;
  logic        done_pulse;
  logic [15:0] done_cnt;
  logic        err_timeout;

  int n_vec = 0;
  int n_err = 0;

  sblk_inst_sched dut (
    .clk_l        (clk_l),
    .rst          (rst),
    .inst_in_data (inst_in_data),
    .inst_in_vld  (inst_in_vld),
    .inst_in_rdy  (inst_in_rdy),
    .flush        (flush),
    .inst_data    (inst_data),
    .inst_en      (inst_en),
    .status_sblk  (status_sblk),
    .sched_idle   (sched_idle),
    .done_pulse   (done_pulse),
    .done_cnt     (done_cnt),
    .err_timeout  (err_timeout)
  );

  always #5 clk_l = ~clk_l;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_l);
    #1;
  endtask

  task automatic push_word(input logic [14:0] w);
    inst_in_data = w;
    inst_in_vld  = 1'b1;
    step();
    inst_in_vld  = 1'b0;
  endtask

  // Waits (bounded) for the ISSUE cycle and checks the word presented.
  task automatic wait_issue(input string tag, input logic [14:0] w);
    logic seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = inst_en;
    end
    check({tag, "_en"}, 32'(seen), 32'd1);
    check({tag, "_data"}, 32'(inst_data), 32'(w));
  endtask

  // Waits (bounded) for done_pulse, then steps back into IDLE.
  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = done_pulse;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    step();
  endtask

  task automatic complete(input string tag);
    status_sblk = 1'b1;
    step();
    step();
    status_sblk = 1'b0;
    wait_done(tag);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    logic seen_en = 1'b0;
    logic seen_dp = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      seen_en |= inst_en;
      seen_dp |= done_pulse;
    end
    check({tag, "_no_en"}, 32'(seen_en), 32'd0);
    check({tag, "_no_done"}, 32'(seen_dp), 32'd0);
    check({tag, "_idle"}, 32'(sched_idle), 32'd1);
  endtask

  logic [14:0] words [5];
  int          pulse_at;
  int          pulses;

  initial begin
    rst = 1'b1; inst_in_data = '0; inst_in_vld = 1'b0; flush = 1'b0; status_sblk = 1'b0;
    words[0] = 15'h0101; words[1] = 15'h0202; words[2] = 15'h7ABC;
    words[3] = 15'h5555; words[4] = 15'h2AAA;

    // Reset values, before any clock edge
    #2;
    check("rst_en", 32'(inst_en), 32'd0);
    check("rst_data", 32'(inst_data), 32'd0);
    check("rst_cnt", 32'(done_cnt), 32'd0);
    check("rst_pulse", 32'(done_pulse), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_idle", 32'(sched_idle), 32'd1);
    check("rst_rdy", 32'(inst_in_rdy), 32'd0);
    step(); step();
    check("rst_rdy_held", 32'(inst_in_rdy), 32'd0);
    rst = 1'b0;
    step();
    check("rdy_after_rel", 32'(inst_in_rdy), 32'd1);

    // Single push: issue two cycles later, then drain timing after status falls
    push_word(15'h1234);
    check("t1_en_c1", 32'(inst_en), 32'd0);
    check("t1_busy", 32'(sched_idle), 32'd0);
    step();
    check("t1_en_c2", 32'(inst_en), 32'd1);
    check("t1_data", 32'(inst_data), 32'h1234);
    step();
    check("t1_en_off", 32'(inst_en), 32'd0);
    check("t1_data_hold", 32'(inst_data), 32'h1234);
    status_sblk = 1'b1;
    repeat (5) step();
    status_sblk = 1'b0;
    pulse_at = 0; pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (done_pulse) begin
        pulses++;
        if (pulse_at == 0) pulse_at = k;
      end
    end
    check("t1_pulse_at", 32'(pulse_at), 32'd3);
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_cnt", 32'(done_cnt), 32'd1);
    check("t1_idle", 32'(sched_idle), 32'd1);

    // Fill with the FSM stalled by status_sblk: 4 accepted, 5th refused, in-order issue
    status_sblk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill_rdy%0d", i), 32'(inst_in_rdy), (i < 4) ? 32'd1 : 32'd0);
      push_word(words[i]);
    end
    check("fill_full", 32'(inst_in_rdy), 32'd0);
    status_sblk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_issue($sformatf("fill_iss%0d", i), words[i]);
      complete($sformatf("fill_cmp%0d", i));
    end
    watch_quiet("fill_end", 10);
    check("fill_cnt", 32'(done_cnt), 32'd5);

    // Flush during WAIT_DONE, with a same-cycle push that must be dropped
    status_sblk = 1'b1;
    push_word(15'h0011); push_word(15'h0022); push_word(15'h0033);
    status_sblk = 1'b0;
    wait_issue("fl_iss", 15'h0011);
    status_sblk = 1'b1;
    step(); step();
    flush = 1'b1; inst_in_vld = 1'b1; inst_in_data = 15'h7777;
    step();
    flush = 1'b0; inst_in_vld = 1'b0;
    check("fl_inflight", 32'(sched_idle), 32'd0);
    status_sblk = 1'b0;
    wait_done("fl");
    check("fl_cnt", 32'(done_cnt), 32'd6);
    watch_quiet("fl_end", 12);

    // Flush in ISSUE still issues the sampled head; the remainder is discarded
    status_sblk = 1'b1;
    push_word(15'h0A0A); push_word(15'h0B0B);
    status_sblk = 1'b0;
    wait_issue("fi_iss", 15'h0A0A);
    flush = 1'b1;
    step();
    flush = 1'b0;
    status_sblk = 1'b1;
    step();
    status_sblk = 1'b0;
    wait_done("fi");
    check("fi_cnt", 32'(done_cnt), 32'd7);
    watch_quiet("fi_end", 12);

    // Reset asserted in WAIT_DONE with a word still queued
    status_sblk = 1'b1;
    push_word(15'h0C0C); push_word(15'h0D0D);
    status_sblk = 1'b0;
    wait_issue("mr_iss", 15'h0C0C);
    status_sblk = 1'b1;
    step(); step();
    #2 rst = 1'b1;
    #1;
    check("mr_en", 32'(inst_en), 32'd0);
    check("mr_data", 32'(inst_data), 32'd0);
    check("mr_cnt", 32'(done_cnt), 32'd0);
    check("mr_pulse", 32'(done_pulse), 32'd0);
    check("mr_idle", 32'(sched_idle), 32'd1);
    check("mr_rdy", 32'(inst_in_rdy), 32'd0);
    step();
    rst = 1'b0;
    status_sblk = 1'b0;
    watch_quiet("mr_after", 10);
    check("mr_cnt_after", 32'(done_cnt), 32'd0);

`ifdef SBLK_SCHED_TIMEOUT_EN
    // status_sblk never rises: error after 64 WAIT_START cycles, back to IDLE
    push_word(15'h0E0E);
    wait_issue("to_iss", 15'h0E0E);
    pulse_at = 0;
    for (int k = 1; k <= 200 && pulse_at == 0; k++) begin
      step();
      if (err_timeout) pulse_at = k;
    end
    check("to_cycles", 32'(pulse_at), 32'd65);
    check("to_idle", 32'(sched_idle), 32'd1);
    check("to_cnt", 32'(done_cnt), 32'd0);
    watch_quiet("to_after", 5);
    check("to_sticky", 32'(err_timeout), 32'd1);
`else
    check("err_tied", 32'(err_timeout), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
